// File: rtl/arith_sweep_ctrl.sv
// Sequential initiator for the combinational arithmetic unit: latches an operand
// pair, sweeps every opcode, and queues tagged results in a show-ahead FIFO.
module arith_sweep_ctrl #(
  parameter int DATA_W     = 16,
  parameter int RES_W      = 32,
  parameter int NUM_OPS    = 8,
  parameter int SETTLE     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [DATA_W-1:0] start_a,
  input  logic [DATA_W-1:0] start_b,
  output logic [DATA_W-1:0] au_a,
  output logic [DATA_W-1:0] au_b,
  output logic [2:0]        au_opcode,
  input  logic [RES_W-1:0]  au_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic [2:0]        res_opcode,
  output logic              res_last,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int EW    = RES_W + 4;

  typedef enum logic {IDLE, DRIVE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [2:0]        op_nxt;
  logic [DATA_W-1:0] a_nxt, b_nxt;
  logic              done_nxt;
  logic              push, pop, full, accept, last;

  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;

  assign full        = (count == (AW+1)'(FIFO_DEPTH));
  assign res_valid   = (count != '0);
  assign pop         = res_valid && res_ready;
  assign last        = (au_opcode == 3'(NUM_OPS - 1));
  // Gated by rst_n so the handshake reads 0 while reset is held.
  assign start_ready = (state == IDLE) && rst_n;
  assign busy        = (state == DRIVE);
  assign accept      = start_valid && start_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      au_opcode <= '0;
      au_a      <= '0;
      au_b      <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      au_opcode <= op_nxt;
      au_a      <= a_nxt;
      au_b      <= b_nxt;
      done      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_nxt    = au_opcode;
    a_nxt     = au_a;
    b_nxt     = au_b;
    done_nxt  = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE: begin
        op_nxt = '0;
        if (accept) begin
          a_nxt     = start_a;
          b_nxt     = start_b;
          cnt_nxt   = '0;
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt != CNT_W'(SETTLE - 1)) begin
          cnt_nxt = cnt + 1'b1;
        end else if (!full || pop) begin
          // A pop in the same cycle frees a slot even when full.
          push    = 1'b1;
          cnt_nxt = '0;
          if (last) begin
            done_nxt  = 1'b1;
            op_nxt    = '0;
            state_nxt = IDLE;
          end else begin
            op_nxt = au_opcode + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {last, au_opcode, au_result};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign {res_last, res_opcode, res_data} = res_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_arith_sweep_ctrl.sv
// Scoreboard bench: two controllers (SETTLE=1 and SETTLE=3), each driving a
// behavioural arithmetic unit; expected sweeps are queued and checked on pop.
module tb_arith_sweep_ctrl;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        sv [2] = '{1'b0, 1'b0};
  logic [15:0] sa [2] = '{16'h0, 16'h0};
  logic [15:0] sb [2] = '{16'h0, 16'h0};
  logic        rr [2] = '{1'b0, 1'b0};
  logic        srdy [2], rv [2], rl [2], bz [2], dn [2];
  logic [15:0] aa [2], ab [2];
  logic [2:0]  aop [2], rop [2];
  logic [31:0] ar [2], rd [2];

  int          mode [2] = '{1, 1};   // 0: ready low, 1: ready high, 2: random
  logic [35:0] exp_q [2][$];
  int          exp_done [2] = '{0, 0};
  int          done_seen [2] = '{0, 0};
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  arith_sweep_ctrl #(.SETTLE(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv[0]), .start_ready(srdy[0]),
    .start_a(sa[0]), .start_b(sb[0]), .au_a(aa[0]), .au_b(ab[0]),
    .au_opcode(aop[0]), .au_result(ar[0]), .res_valid(rv[0]), .res_ready(rr[0]),
    .res_data(rd[0]), .res_opcode(rop[0]), .res_last(rl[0]), .busy(bz[0]), .done(dn[0])
  );

  arith_sweep_ctrl #(.SETTLE(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv[1]), .start_ready(srdy[1]),
    .start_a(sa[1]), .start_b(sb[1]), .au_a(aa[1]), .au_b(ab[1]),
    .au_opcode(aop[1]), .au_result(ar[1]), .res_valid(rv[1]), .res_ready(rr[1]),
    .res_data(rd[1]), .res_opcode(rop[1]), .res_last(rl[1]), .busy(bz[1]), .done(dn[1])
  );

  assign ar[0] = {13'd0, aop[0], aa[0] + ab[0]};
  assign ar[1] = {13'd0, aop[1], ab[1] + aa[1]};

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++)
      rr[i] = (mode[i] == 2) ? 1'($urandom_range(0, 1)) : (mode[i] == 1);
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (dn[i]) done_seen[i]++;
      if (rv[i] && rr[i]) begin
        if (exp_q[i].size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result dut%0d: got %h expected none", i, {rl[i], rop[i], rd[i]});
        end else begin
          check($sformatf("result_dut%0d", i), {rl[i], rop[i], rd[i]}, exp_q[i].pop_front());
        end
      end
    end
  end

  // One sweep's worth of results as the consumer should see them.
  task automatic push_exp(input int id, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] s;
    s = a + b;
    for (int k = 0; k < 8; k++)
      exp_q[id].push_back({(k == 7), 3'(k), 13'd0, 3'(k), s});
    exp_done[id]++;
  endtask

  task automatic wait_accept(input int id, output int n, output logic d);
    n = 0;
    d = 1'b0;
    forever begin
      @(negedge clk);
      if (srdy[id]) begin
        d = dn[id];
        break;
      end
      n++;
      if (n > 1000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout dut%0d: got no start_ready required start_ready", id);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int id, input logic [15:0] a, input logic [15:0] b);
    int   n;
    logic d;
    sa[id] = a;
    sb[id] = b;
    sv[id] = 1'b1;
    wait_accept(id, n, d);
    sv[id] = 1'b0;
    push_exp(id, a, b);
  endtask

  task automatic timed_sweep(input int id, input logic [15:0] a, input logic [15:0] b, input int cyc);
    int n, nb;
    start(id, a, b);
    n  = 0;
    nb = 0;
    while (!dn[id] && n < 1000) begin
      if (bz[id]) nb++;
      check($sformatf("opcode_step_dut%0d", id), aop[id], n / (cyc / 8));
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("done_latency_dut%0d", id), n, cyc);
    check($sformatf("busy_cycles_dut%0d", id), nb, cyc);
    check($sformatf("busy_at_done_dut%0d", id), bz[id], 0);
  endtask

  initial begin
    int          n;
    logic        d;
    logic [15:0] a, b;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_ready_dut%0d", i), srdy[i], 1);
      check($sformatf("rst_valid_dut%0d", i), rv[i], 0);
      check($sformatf("rst_busy_dut%0d", i), bz[i], 0);
      check($sformatf("rst_ab_dut%0d", i), {aa[i], ab[i], aop[i]}, 0);
    end
    @(posedge clk);
    #1;

    fork
      timed_sweep(0, 16'h0001, 16'h0010, 8);
      timed_sweep(1, 16'h0002, 16'h0003, 24);
    join
    repeat (4) @(posedge clk);
    #1;

    // Back-pressure: FIFO fills, opcode stalls at 4.
    mode[0] = 0;
    @(posedge clk);
    #1;
    start(0, 16'($urandom), 16'($urandom));
    repeat (20) @(posedge clk);
    #1;
    check("bp_opcode", aop[0], 4);
    check("bp_busy", bz[0], 1);
    check("bp_valid", rv[0], 1);
    mode[0] = 1;
    repeat (20) @(posedge clk);
    #1;
    check("bp_idle", bz[0], 0);

    // Overlap: start_valid held high, second pair accepted the cycle after done.
    mode[0] = 2;
    a = 16'($urandom);
    b = 16'($urandom);
    sa[0] = a;
    sb[0] = b;
    sv[0] = 1'b1;
    wait_accept(0, n, d);
    push_exp(0, a, b);
    sa[0] = 16'h0100;
    sb[0] = 16'h0110;
    wait_accept(0, n, d);
    sv[0] = 1'b0;
    push_exp(0, 16'h0100, 16'h0110);
    check("overlap_accept_after_done", d, 1);
    for (int t = 0; t < 500 && (exp_q[0].size() != 0 || bz[0]); t++) @(posedge clk);
    #1;
    check("overlap_drained", exp_q[0].size(), 0);

    // Abort mid-sweep with an asynchronous reset.
    mode[0] = 1;
    @(posedge clk);
    #1;
    start(0, 16'($urandom), 16'($urandom));
    for (int t = 0; t < 100 && aop[0] != 3'd5; t++) begin
      @(posedge clk);
      #1;
    end
    check("abort_opcode_reached", aop[0], 5);
    rst_n = 1'b0;
    #1;
    check("abort_valid", rv[0], 0);
    check("abort_busy", bz[0], 0);
    check("abort_done", dn[0], 0);
    check("abort_outs", {aa[0], ab[0], aop[0], rd[0], rop[0], rl[0]}, 0);
    exp_q[0].delete();
    exp_done[0]--;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_abort_ready", srdy[0], 1);
    check("post_abort_valid", rv[0], 0);
    timed_sweep(0, 16'($urandom), 16'($urandom), 8);

    // Random traffic on both controllers.
    mode[0] = 2;
    mode[1] = 2;
    fork
      for (int j = 0; j < 4; j++) begin
        repeat ($urandom_range(0, 5)) @(posedge clk);
        #1;
        start(0, 16'($urandom), 16'($urandom));
      end
      for (int j = 0; j < 4; j++) begin
        repeat ($urandom_range(0, 5)) @(posedge clk);
        #1;
        start(1, 16'($urandom), 16'($urandom));
      end
    join
    for (int t = 0; t < 3000 &&
         (exp_q[0].size() != 0 || exp_q[1].size() != 0 || bz[0] || bz[1]); t++)
      @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("final_queue_dut%0d", i), exp_q[i].size(), 0);
      check($sformatf("final_valid_dut%0d", i), rv[i], 0);
      check($sformatf("done_pulses_dut%0d", i), done_seen[i], exp_done[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

endmodule
